// File: rtl/seg7_display_pkg.sv
// Shared definitions for the seven-segment display peripheral: register
// offsets, CTRL field positions and the blank drive levels.
package seg7_display_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_NONE   = 2'd3
  } reg_off_e;

  localparam int CTRL_EN_LSB    = 0;
  localparam int CTRL_BLINK_BIT = 8;
  localparam int CTRL_DOT_LSB   = 16;

  // Only the enable mask, blink bit and dot mask are stored.
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_01FF;
  localparam logic [31:0] CTRL_RESET = 32'h0000_00FF;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/seg7_display_hex_to_seg.sv
// Combinational hex digit to active-low segment decoder (seg[0]=a .. seg[6]=g).
module seg7_display_hex_to_seg
  import seg7_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Active-low g..a pattern for each hex value.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg7_display.sv
// Bus-mapped 8-digit common-anode seven-segment display driver with
// time-multiplexed scan, per-digit enable/dot masks and frame-based blink.
module seg7_display
  import seg7_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic [1:0]  sel_i,
  input  logic        rd_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [31:0]        data_p0;
  logic [31:0]        ctrl_p0;
  logic [PRESC_W-1:0] presc_p0;
  logic [2:0]         idx_p0;
  logic [FRAME_W-1:0] frame_p0;
  logic               blink_p0;

  logic [7:0] an_p1;
  logic [6:0] seg_p1;
  logic       dp_p1;

  logic [7:0] en_mask;
  logic [7:0] dot_mask;
  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       blank;

  // Access width and read strobe carry no meaning for this block.
  logic unused_bus;
  assign unused_bus = &{1'b0, sel_i, rd_i, addr_i[31:4], addr_i[1:0]};

  assign ack_o = 1'b1;

  // Bus writes into DATA and CTRL; STATUS and offset 3 ignore writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p0 <= '0;
      ctrl_p0 <= CTRL_RESET;
    end else if (we_i) begin
      case (reg_off_e'(addr_i[3:2]))
        REG_DATA: data_p0 <= data_i;
        REG_CTRL: ctrl_p0 <= data_i & CTRL_WMASK;
        default:  ;
      endcase
    end
  end

  // Scan prescaler, digit index, frame counter and blink phase; free-running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
      frame_p0 <= '0;
      blink_p0 <= 1'b0;
    end else if (presc_p0 == PRESC_LAST) begin
      presc_p0 <= '0;
      idx_p0   <= idx_p0 + 3'd1;
      if (idx_p0 == 3'd7) begin
        if (frame_p0 == FRAME_LAST) begin
          frame_p0 <= '0;
          blink_p0 <= ~blink_p0;
        end else begin
          frame_p0 <= frame_p0 + FRAME_W'(1);
        end
      end
    end else begin
      presc_p0 <= presc_p0 + PRESC_W'(1);
    end
  end

  assign en_mask  = ctrl_p0[CTRL_EN_LSB +: 8];
  assign dot_mask = ctrl_p0[CTRL_DOT_LSB +: 8];
  assign nibble   = data_p0[{idx_p0, 2'b00} +: 4];
  assign blank    = ~en_mask[idx_p0] | (ctrl_p0[CTRL_BLINK_BIT] & blink_p0);

  seg7_display_hex_to_seg u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // ---- stage p0 -> p1: registered pin drive for the selected digit ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
    end else if (blank) begin
      an_p1  <= AN_OFF;
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
    end else begin
      an_p1  <= ~(8'b1 << idx_p0);
      seg_p1 <= seg_dec;
      dp_p1  <= ~dot_mask[idx_p0];
    end
  end

  assign an  = an_p1;
  assign seg = seg_p1;
  assign dp  = dp_p1;

  // Combinational register read-back.
  always_comb begin
    data_o = '0;
    case (reg_off_e'(addr_i[3:2]))
      REG_DATA:   data_o = data_p0;
      REG_CTRL:   data_o = ctrl_p0;
      REG_STATUS: data_o = {28'd0, blink_p0, idx_p0};
      default:    data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_seg7_display.sv
// Randomised bench for seg7_display against a cycle-count based model.
module tb_seg7_display;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [1:0]  sel_i = '0;
  logic        rd_i = 1'b0;
  logic        we_i = 1'b0;
  logic        ack_o;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  // Model state: clock edges since reset release, and register contents.
  int          k = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_ctrl = 32'h0000_00FF;

  seg7_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_o(data_o), .data_i(data_i),
    .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i), .ack_o(ack_o),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input int c);
    return (c / SD) % 8;
  endfunction

  function automatic int m_bp(input int c);
    return (c / (SD * 8 * BF)) % 2;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return m_ctrl;
      2'd2:    return {28'd0, 1'(m_bp(k)), 3'(m_idx(k))};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Pins expected after the next edge, from the state before that edge.
  task automatic expect_pins(output logic [7:0] e_an, output logic [6:0] e_seg, output logic e_dp);
    int i;
    bit lit;
    i = m_idx(k);
    lit = m_ctrl[i] && !(m_ctrl[8] && m_bp(k) == 1);
    if (lit) begin
      e_an  = ~(8'd1 << i);
      e_seg = HEX[m_data[4*i +: 4]];
      e_dp  = ~m_ctrl[16+i];
    end else begin
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end
  endtask

  task automatic step(input bit we, input logic [1:0] waddr, input logic [31:0] wdata);
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] raddr;
    @(negedge clk);
    we_i   = we;
    addr_i = {28'($urandom), waddr, 2'($urandom)};
    data_i = wdata;
    rd_i   = 1'($urandom);
    sel_i  = 2'($urandom);
    expect_pins(e_an, e_seg, e_dp);
    @(posedge clk);
    #1;
    if (we) begin
      if (waddr == 2'd0) m_data = wdata;
      else if (waddr == 2'd1) m_ctrl = wdata & 32'h00FF_01FF;
    end
    k++;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    we_i   = 1'b0;
    raddr  = 2'($urandom);
    addr_i = {28'($urandom), raddr, 2'($urandom)};
    #1;
    chk("read", data_o, exp_read(raddr));
    chk("ack", 32'(ack_o), 32'd1);
  endtask

  initial begin
    // Held in reset: blank pins and reset register values.
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
    end
    for (int a = 0; a < 4; a++) begin
      addr_i = 32'(a) << 2;
      #1;
      chk("rst_read", data_o, exp_read(2'(a)));
    end
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Scan order with distinct digit values.
    step(1'b1, 2'd0, 32'h7654_3210);
    repeat (40) step(1'b0, 2'd0, 32'h0);

    // Enable mask and dot mask.
    step(1'b1, 2'd1, 32'h0001_0005);
    repeat (32) step(1'b0, 2'd0, 32'h0);

    // Blink across at least two phase changes.
    step(1'b1, 2'd1, 32'h0000_01FF);
    repeat (140) step(1'b0, 2'd0, 32'h0);

    // Write landing while digit 3 is selected.
    step(1'b1, 2'd1, 32'h0000_00FF);
    for (int n = 0; n < 40 && m_idx(k) != 3; n++) step(1'b0, 2'd0, 32'h0);
    step(1'b1, 2'd0, 32'hFFFF_FFFF);
    repeat (8) step(1'b0, 2'd0, 32'h0);

    // Random bus traffic, including writes to read-only offsets.
    repeat (300) step(($urandom % 4) == 0, 2'($urandom), $urandom);

    // Asynchronous reset mid-scan at digit 5.
    step(1'b1, 2'd1, 32'h00FF_00FF);
    for (int n = 0; n < 64 && !(m_idx(k) == 5 && (k % SD) == 2); n++) step(1'b0, 2'd0, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hFF);
    chk("async_seg", 32'(seg), 32'h7F);
    chk("async_dp", 32'(dp), 32'd1);
    m_data = '0;
    m_ctrl = 32'h0000_00FF;
    k = 0;
    addr_i = 32'h8;
    #1;
    chk("async_status", data_o, exp_read(2'd2));
    @(posedge clk);
    #1;
    chk("async_hold_an", 32'(an), 32'hFF);
    #1;
    rst = 1'b1;
    repeat (40) step(1'b0, 2'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_display.md
Name: seg7_display

Overview:
- Bus-mapped output peripheral; the output-direction counterpart to the switch input block.
- Sits on the same simple slave bus (addr/data/rd/we/ack).
- CPU writes an 8-digit hex value plus control bits; the block time-multiplexes them onto an 8-digit common-anode seven-segment display, with optional blink.
- All outputs are registered.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot. Must be ≥2.
- BLINK_FRAMES, 64, full 8-digit frames per blink phase. Must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (asserted at 0)
- addr_i  in  32  byte address; only addr_i[3:2] decoded
- data_o  out  32  read data
- data_i  in  32  write data
- sel_i  in  2  unused; all accesses are full 32-bit
- rd_i  in  1  read strobe
- we_i  in  1  write strobe
- ack_o  out  1  access acknowledge
- an  out  8  digit anodes, active-low; an[i] is digit i
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low

Behaviour:
- Bus:
  - ack_o is tied to 1. Reads are combinational from current register state.
  - A write takes effect at the clk edge on which we_i=1.
  - rd_i has no side effects.
- Register map (addr_i[3:2]):
  - 0 DATA: R/W 32 bits. Digit i shows DATA[4i+3:4i].
  - 1 CTRL: R/W. [7:0] digit enable mask; [8] blink enable; [23:16] dot mask (1 = dp lit on that digit). Unimplemented bits are ignored on write and read as 0.
  - 2 STATUS: RO. [2:0] current scan index; [3] blink_phase; other bits 0. Writes ignored.
  - 3: reads 0; writes ignored.
- Reset (rst=0, asynchronous):
  - DATA=0, CTRL=0x000000FF.
  - presc=0, idx=0, frame_cnt=0, blink_phase=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- Scan:
  - presc counts 0..SCAN_DIV-1. On presc==SCAN_DIV-1: presc←0 and idx←idx+1 mod 8 (7 wraps to 0).
  - idx advances regardless of the enable mask, so duty cycle stays constant.
- Frames/blink:
  - When idx wraps 7→0, frame_cnt increments.
  - When frame_cnt==BLINK_FRAMES-1 at a wrap: frame_cnt←0 and blink_phase toggles.
  - These counters run even when blink is disabled.
- Output register (every cycle, from current idx and registers):
  - blank = !CTRL[idx] | (CTRL[8] & blink_phase).
  - an ← blank ? 8'hFF : ~(8'b1<<idx).
  - seg ← blank ? 7'h7F : hex_to_seg(DATA nibble idx).
  - dp ← blank ? 1 : ~CTRL[16+idx].
- Latency: outputs lag idx/register changes by exactly 1 clk. A write to DATA/CTRL is visible on pins 1 cycle after the write edge, provided the digit is currently selected.
- Simultaneous events:
  - A write coinciding with an idx advance: both take effect. The next output uses the new idx with the new register value.
  - Writes never disturb presc, idx or frame_cnt.
- Reset mid-scan: all outputs go immediately to the blank reset values. Scan restarts at idx 0, presc 0, 1 cycle after deassertion.
- Hex decode, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Shared package:
  - register offsets (DATA=0, CTRL=1, STATUS=2)
  - CTRL field positions (EN 7:0, BLINK 8, DOT 23:16)
  - SEG_BLANK=7'h7F, AN_OFF=8'hFF
- One sub-module: hex_to_seg, a combinational 4→7 decoder, instantiated once.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Reset values: hold rst=0 → an=FF, seg=7F, dp=1. Read DATA=0, CTRL=0x000000FF, STATUS=0.
- Scan order and timing:
  - Write DATA=0x76543210 after reset → an cycles FE, FD, FB, … 7F, FE; each value is held 4 clks.
  - seg on an=FE is 1000000; on an=7F it is 1111000.
- Enable mask and dots: CTRL=0x00010005 → digits 0 and 2 lit, digits 1 and 3–7 give an=FF with seg=7F. dp=0 only while digit 0 is lit.
- Blink: CTRL=0x000001FF → display is on for 2 frames (64 clks), then fully blank for 64 clks, then on again. STATUS[3] toggles every 64 clks.
- Write latency: write DATA=0xFFFFFFFF while digit 3 is selected → seg=0001110 on the cycle after the write edge. presc and idx timing are unaffected.
- Async reset mid-scan: assert rst at idx=5 between clk edges → an=FF immediately. After release, the first lit digit is an=FE.
